// File: rtl/vsm_sequencer.sv
// Job controller for the vsm lane array: clears the accumulators, feeds ACCUMULATIONS
// weight/scalar pairs one enable at a time, waits for the array to settle, then captures the result.
module vsm_sequencer #(
    parameter int SIZE          = 6,
    parameter int WIDTH         = 8,
    parameter int ACCUMULATIONS = 3,
    parameter int ADDR_W        = 4,
    parameter int DRAIN_CYCLES  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    output logic                    busy,
    output logic                    done,
    output logic [WIDTH*SIZE-1:0]   result,
    output logic                    w_rd_en,
    output logic [ADDR_W-1:0]       w_addr,
    input  logic [WIDTH*SIZE-1:0]   w_data,
    output logic                    x_rd_en,
    output logic [ADDR_W-1:0]       x_addr,
    input  logic [WIDTH-1:0]        x_data,
    output logic                    vsm_clr_n,
    output logic                    vsm_enable,
    output logic [WIDTH*SIZE-1:0]   vsm_a,
    output logic [WIDTH-1:0]        vsm_b,
    input  logic [WIDTH*SIZE-1:0]   vsm_out
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_MAC   = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [ADDR_W-1:0] K_LAST   = ADDR_W'(ACCUMULATIONS - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);

    logic [2:0]            state_q, state_d;
    logic [ADDR_W-1:0]     k_q, k_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [WIDTH*SIZE-1:0] result_q, result_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic                  enable_q, enable_d;

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_CLEAR;
            S_CLEAR: begin
                k_d     = '0;
                state_d = S_FETCH;
            end
            S_FETCH: state_d = S_MAC;
            S_MAC: begin
                if (k_q == K_LAST) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    k_d     = k_q + 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_DRAIN: begin
                if (cnt_q == CNT_LAST) begin
                    result_d = vsm_out;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // abort overrides every transition out of a busy state and leaves the old result intact
        if (abort && (state_q != S_IDLE)) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    // Registered outputs are decoded from the next state so they line up with the state they belong to.
    always_comb begin
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);
        rd_en_d  = (state_d == S_FETCH);
        enable_d = (state_d == S_MAC);
        addr_d   = (state_d == S_FETCH) ? k_d : addr_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rd_en_q  <= 1'b0;
            addr_q   <= '0;
            enable_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rd_en_q  <= rd_en_d;
            addr_q   <= addr_d;
            enable_q <= enable_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign result     = result_q;
    assign w_rd_en    = rd_en_q;
    assign x_rd_en    = rd_en_q;
    assign w_addr     = addr_q;
    assign x_addr     = addr_q;
    assign vsm_enable = enable_q;
    assign vsm_a      = w_data;
    assign vsm_b      = x_data;
    assign vsm_clr_n  = reset & (state_q != S_CLEAR);

endmodule

// File: tb/tb_vsm_sequencer.sv
// Directed bench for vsm_sequencer: two instances (default and single-accumulation), each with
// synchronous operand memories and a behavioural lane array model.
module tb_vsm_sequencer;
    localparam int SIZE = 6;
    localparam int WIDTH = 8;
    localparam int AW = 4;
    localparam int BW = SIZE * WIDTH;
    localparam logic [BW-1:0] R09 = 48'h090909090909;
    localparam logic [BW-1:0] R03 = 48'h030303030303;
    localparam logic [BW-1:0] R0F = 48'h0F0F0F0F0F0F;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] mac(input logic [BW-1:0] acc, input logic [BW-1:0] a,
                                          input logic [WIDTH-1:0] b);
        logic [BW-1:0] r;
        for (int l = 0; l < SIZE; l++) r[l*WIDTH +: WIDTH] = acc[l*WIDTH +: WIDTH] + WIDTH'(a[l*WIDTH +: WIDTH] * b);
        return r;
    endfunction

    // ---------------- instance A: default parameters ----------------
    logic a_start, a_abort, a_busy, a_done, a_wrd, a_xrd, a_clrn, a_en;
    logic [BW-1:0] a_result, a_wdata, a_va, a_acc;
    logic [AW-1:0] a_waddr, a_xaddr;
    logic [WIDTH-1:0] a_xdata, a_vb;
    logic [BW-1:0] a_wmem [16];
    logic [WIDTH-1:0] a_xmem [16];

    vsm_sequencer dut_a (
        .clk(clk), .reset(reset), .start(a_start), .abort(a_abort),
        .busy(a_busy), .done(a_done), .result(a_result),
        .w_rd_en(a_wrd), .w_addr(a_waddr), .w_data(a_wdata),
        .x_rd_en(a_xrd), .x_addr(a_xaddr), .x_data(a_xdata),
        .vsm_clr_n(a_clrn), .vsm_enable(a_en), .vsm_a(a_va), .vsm_b(a_vb), .vsm_out(a_acc)
    );

    always @(posedge clk) begin
        if (a_wrd) a_wdata <= a_wmem[a_waddr];
        if (a_xrd) a_xdata <= a_xmem[a_xaddr];
    end
    always @(posedge clk or negedge a_clrn) begin
        if (!a_clrn) a_acc <= '0;
        else if (a_en) a_acc <= mac(a_acc, a_va, a_vb);
    end

    int a_en_cnt = 0, a_done_cnt = 0, a_mis = 0;
    logic [AW-1:0] a_addrs [$];
    always @(posedge clk) begin
        if (a_en) a_en_cnt++;
        if (a_done) a_done_cnt++;
        if (a_wrd) a_addrs.push_back(a_waddr);
        if (a_xrd !== a_wrd || a_xaddr !== a_waddr || a_va !== a_wdata || a_vb !== a_xdata) a_mis++;
    end

    // ---------------- instance B: ACCUMULATIONS=1, DRAIN_CYCLES=1 ----------------
    logic b_start, b_abort, b_busy, b_done, b_wrd, b_xrd, b_clrn, b_en;
    logic [BW-1:0] b_result, b_wdata, b_va, b_acc;
    logic [AW-1:0] b_waddr, b_xaddr;
    logic [WIDTH-1:0] b_xdata, b_vb;
    logic [BW-1:0] b_wmem [16];
    logic [WIDTH-1:0] b_xmem [16];

    vsm_sequencer #(.SIZE(SIZE), .WIDTH(WIDTH), .ACCUMULATIONS(1), .ADDR_W(AW), .DRAIN_CYCLES(1)) dut_b (
        .clk(clk), .reset(reset), .start(b_start), .abort(b_abort),
        .busy(b_busy), .done(b_done), .result(b_result),
        .w_rd_en(b_wrd), .w_addr(b_waddr), .w_data(b_wdata),
        .x_rd_en(b_xrd), .x_addr(b_xaddr), .x_data(b_xdata),
        .vsm_clr_n(b_clrn), .vsm_enable(b_en), .vsm_a(b_va), .vsm_b(b_vb), .vsm_out(b_acc)
    );

    always @(posedge clk) begin
        if (b_wrd) b_wdata <= b_wmem[b_waddr];
        if (b_xrd) b_xdata <= b_xmem[b_xaddr];
    end
    always @(posedge clk or negedge b_clrn) begin
        if (!b_clrn) b_acc <= '0;
        else if (b_en) b_acc <= mac(b_acc, b_va, b_vb);
    end

    int b_en_cnt = 0;
    logic [AW-1:0] b_addrs [$];
    always @(posedge clk) begin
        if (b_en) b_en_cnt++;
        if (b_wrd) b_addrs.push_back(b_waddr);
    end

    // Runs one job on A from the current falling edge; cycle 1 is the CLEAR cycle.
    task automatic run_a(input int pulse_start_at, input int abort_at, input int budget,
                         output int done_cyc, output logic busy1, output logic clrn1,
                         output logic busy_ab, output logic en_ab);
        a_start = 1'b1;
        done_cyc = 0; busy1 = 1'bx; clrn1 = 1'bx; busy_ab = 1'bx; en_ab = 1'bx;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (c == 1) begin busy1 = a_busy; clrn1 = a_clrn; end
            if (c == 1 || c == pulse_start_at + 1) a_start = 1'b0;
            if (c == pulse_start_at) a_start = 1'b1;
            a_abort = (c == abort_at);
            if (c == abort_at + 1) begin busy_ab = a_busy; en_ab = a_en | a_wrd; end
            if (a_done && done_cyc == 0) done_cyc = c;
        end
    endtask

    initial begin
        int e0, d0, q0, dc, d1, d2, clr2;
        logic bs1, cl1, bab, eab;
        logic [BW-1:0] r1;

        reset = 1'b0;
        a_start = 1'b0; a_abort = 1'b0; b_start = 1'b0; b_abort = 1'b0;
        for (int i = 0; i < 16; i++) begin
            a_wmem[i] = {SIZE{8'h01}}; a_xmem[i] = 8'h00;
            b_wmem[i] = {SIZE{8'h05}}; b_xmem[i] = 8'h03;
        end
        a_xmem[0] = 8'd2; a_xmem[1] = 8'd3; a_xmem[2] = 8'd4;

        repeat (2) @(negedge clk);
        check("rst_busy", a_busy, 1'b0);
        check("rst_done", a_done, 1'b0);
        check("rst_rden", {a_wrd, a_xrd}, 2'b00);
        check("rst_en", a_en, 1'b0);
        check("rst_addr", {a_waddr, a_xaddr}, 8'h00);
        check("rst_result", a_result, 48'h0);
        check("rst_clrn", a_clrn, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_clrn", a_clrn, 1'b1);
        check("idle_busy", a_busy, 1'b0);

        // job 1 with a second start pulse during the first MAC cycle
        e0 = a_en_cnt; d0 = a_done_cnt; q0 = a_addrs.size();
        run_a(3, 0, 16, dc, bs1, cl1, bab, eab);
        check("j1_busy_c1", bs1, 1'b1);
        check("j1_clrn_c1", cl1, 1'b0);
        check("j1_done_cyc", dc, 10);
        check("j1_result", a_result, R09);
        check("j1_en_pulses", a_en_cnt - e0, 3);
        check("j1_done_cnt", a_done_cnt - d0, 1);
        check("j1_addr_cnt", a_addrs.size() - q0, 3);
        for (int i = 0; i < 3; i++) check("j1_addr", a_addrs[q0 + i], i);

        // abort during the second MAC cycle
        e0 = a_en_cnt; d0 = a_done_cnt;
        run_a(0, 5, 16, dc, bs1, cl1, bab, eab);
        check("ab_busy", bab, 1'b0);
        check("ab_enables", eab, 1'b0);
        check("ab_no_done", a_done_cnt - d0, 0);
        check("ab_en_pulses", a_en_cnt - e0, 2);
        check("ab_result", a_result, R09);

        // start held high: one IDLE cycle, then a second job with x={1,1,1}
        a_start = 1'b1; d1 = 0; d2 = 0; clr2 = 0; r1 = '0;
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            if (a_done && d1 == 0) begin
                d1 = c; r1 = a_result;
                for (int i = 0; i < 3; i++) a_xmem[i] = 8'd1;
            end else if (a_done && d2 == 0) begin
                d2 = c;
            end
            if (d1 != 0 && clr2 == 0 && !a_clrn) begin clr2 = c; a_start = 1'b0; end
        end
        check("bb_done1_cyc", d1, 10);
        check("bb_result1", r1, R09);
        check("bb_clear2_cyc", clr2, 12);
        check("bb_done2_cyc", d2, 21);
        check("bb_result2", a_result, R03);

        // asynchronous reset during DRAIN
        d0 = a_done_cnt;
        a_start = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) a_start = 1'b0;
        end
        reset = 1'b0;
        #1;
        check("ar_busy", a_busy, 1'b0);
        check("ar_done", a_done, 1'b0);
        check("ar_rden", {a_wrd, a_xrd}, 2'b00);
        check("ar_en", a_en, 1'b0);
        check("ar_addr", {a_waddr, a_xaddr}, 8'h00);
        check("ar_result", a_result, 48'h0);
        check("ar_clrn", a_clrn, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        check("ar_idle_busy", a_busy, 1'b0);
        check("ar_no_done", a_done_cnt - d0, 0);
        check("a_port_tracking", a_mis, 0);

        // single-accumulation instance
        e0 = b_en_cnt; q0 = b_addrs.size(); dc = 0;
        b_start = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) b_start = 1'b0;
            if (b_done && dc == 0) dc = c;
        end
        check("b_done_cyc", dc, 5);
        check("b_result", b_result, R0F);
        check("b_en_pulses", b_en_cnt - e0, 1);
        check("b_addr_cnt", b_addrs.size() - q0, 1);
        if (b_addrs.size() > q0) check("b_addr0", b_addrs[q0], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/vsm_sequencer.md
Name: vsm_sequencer

Overview:
- Controller that runs one complete vector-scalar multiply-accumulate job on the vsm lane array.
- On a start command it:
  - clears the MAC accumulators;
  - fetches ACCUMULATIONS weight vectors and input scalars from two synchronous read ports;
  - pulses the array enable once per operand pair;
  - waits for the array output to settle;
  - captures the SIZE-lane result and reports done.
- Sits between the layer-level scheduler (start/done) and the weight/activation buffers plus the vsm instance.

Parameters:
- SIZE, 6, number of lanes (MACs) in the driven vsm.
- WIDTH, 8, lane and scalar width in bits.
- ACCUMULATIONS, 3, operand pairs per job (>=1).
- ADDR_W, 4, address width of both read ports (2**ADDR_W >= ACCUMULATIONS).
- DRAIN_CYCLES, 2, cycles waited after the last enable before result capture (>=1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  job request; sampled only in IDLE.
- abort  input  1  synchronous cancel; returns to IDLE with no done.
- busy  output  1  high in every state except IDLE.
- done  output  1  single-cycle pulse when result is valid.
- result  output  WIDTH*SIZE  captured lane outputs; held until the next capture.
- w_rd_en  output  1  weight read enable.
- w_addr  output  ADDR_W  weight vector index.
- w_data  input  WIDTH*SIZE  weight vector; valid the cycle after w_rd_en.
- x_rd_en  output  1  scalar read enable; identical timing to w_rd_en.
- x_addr  output  ADDR_W  scalar index; always equal to w_addr.
- x_data  input  WIDTH  input scalar; valid the cycle after x_rd_en.
- vsm_clr_n  output  1  active-low accumulator clear to the vsm reset pin.
- vsm_enable  output  1  vsm enable.
- vsm_a  output  WIDTH*SIZE  equals w_data (combinational pass-through).
- vsm_b  output  WIDTH  equals x_data (combinational pass-through).
- vsm_out  input  WIDTH*SIZE  vsm out bus.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; k=0; drain counter=0; result=0.
  - busy, done, rd_ens, vsm_enable = 0; addrs = 0.
  - vsm_clr_n=0 combinationally while reset is low.
  - Reset mid-job discards the job; no done is produced.
- Outputs are registered except vsm_a, vsm_b and vsm_clr_n.
- vsm_clr_n = reset AND (state != CLEAR).
- FSM:
  - IDLE: if start, go to CLEAR.
  - CLEAR (1 cycle): vsm_clr_n=0; k<=0; go to FETCH.
  - FETCH (1 cycle): rd_ens=1; addr=k; go to MAC.
  - MAC (1 cycle): vsm_enable=1 while memory data is valid.
    - If k==ACCUMULATIONS-1, go to DRAIN with drain counter<=0.
    - Otherwise k<=k+1 and go to FETCH.
  - DRAIN: counter increments each cycle. When counter==DRAIN_CYCLES-1, result<=vsm_out and go to DONE.
  - DONE (1 cycle): done=1; go to IDLE.
- Each operand pair costs 2 cycles; there is no fetch/MAC overlap.
- Latency: counting the CLEAR cycle as cycle 1, done is high in cycle 2+2*ACCUMULATIONS+DRAIN_CYCLES. Defaults give cycle 10.
- vsm_enable is never high outside MAC. Exactly ACCUMULATIONS enable pulses occur per job.
- Addresses issued are 0..ACCUMULATIONS-1 in order, each exactly once.
- start outside IDLE is ignored (no queueing); this includes start in the DONE cycle.
- start held continuously restarts immediately, with one IDLE cycle between jobs.
- abort in any non-IDLE state:
  - next state is IDLE; all enables drop; no done is produced; result is unchanged.
  - abort has priority over every other transition. abort in IDLE has no effect.
- Simultaneous start and abort in IDLE: start wins.
- ACCUMULATIONS=1: the sequence is CLEAR, FETCH, MAC, DRAIN, DONE.
- Arithmetic and wrap-around inside the lanes belong to vsm. The controller never modifies data widths or values.

Test Plan:
- Basic job: w[i]=0x01 in all lanes, x={2,3,4}, real vsm attached. Pulse start.
  - busy rises the next cycle; done pulses at cycle 10.
  - result = 0x09 in each lane.
  - Exactly 3 vsm_enable pulses; addresses 0, 1, 2 in order.
- Back-to-back jobs:
  - start held high: second job's CLEAR follows exactly one IDLE cycle after done.
  - Second job with x={1,1,1} gives result 0x03 per lane; accumulator is cleared, not 0x0C.
- Ignored start: pulse start again during MAC of job 1.
  - Exactly one done; enable count stays 3; no extra address.
- Abort: assert abort during the second MAC.
  - busy=0 the next cycle; no done pulse.
  - result keeps its prior value (0x09).
- Async reset: drop reset during DRAIN.
  - All outputs are 0 immediately and vsm_clr_n=0.
  - After release, the FSM sits in IDLE until start.
- ACCUMULATIONS=1, DRAIN_CYCLES=1: w=0x05, x=0x03.
  - done at cycle 5; result 0x0F per lane.
